// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback mux and WB-to-ID bypass.
// Optional WB_RETIRE_COUNT_EN adds a retired-write counter output.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_link,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]       retire_count,
`endif
    output logic              wb_valid,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              byp_a,
    output logic              byp_b
);

    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic              valid_q, valid_d;
    logic              reg_rw_q, reg_rw_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              link_q, link_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;

    // Priority: reset > flush > stall > load; flush is a reset-equivalent bubble.
    always_comb begin
        valid_d      = valid_q;
        reg_rw_d     = reg_rw_q;
        mem_to_reg_d = mem_to_reg_q;
        link_d       = link_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_plus4_d   = pc_plus4_q;
        if (reset || flush) begin
            valid_d      = 1'b0;
            reg_rw_d     = 1'b0;
            mem_to_reg_d = 1'b0;
            link_d       = 1'b0;
            rd_d         = '0;
            alu_result_d = '0;
            read_data_d  = '0;
            pc_plus4_d   = '0;
        end else if (!stall) begin
            valid_d      = mem_valid;
            reg_rw_d     = mem_reg_write;
            mem_to_reg_d = mem_mem_to_reg;
            link_d       = mem_link;
            rd_d         = mem_rd;
            alu_result_d = mem_alu_result;
            read_data_d  = mem_read_data;
            pc_plus4_d   = mem_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        valid_q      <= valid_d;
        reg_rw_q     <= reg_rw_d;
        mem_to_reg_q <= mem_to_reg_d;
        link_q       <= link_d;
        rd_q         <= rd_d;
        alu_result_q <= alu_result_d;
        read_data_q  <= read_data_d;
        pc_plus4_q   <= pc_plus4_d;
    end

    always_comb begin
        if (link_q) begin
            write_data = pc_plus4_q + DATA_W'(4);
        end else if (mem_to_reg_q) begin
            write_data = read_data_q;
        end else begin
            write_data = alu_result_q;
        end
    end

    assign wb_valid       = valid_q;
    assign write_register = link_q ? LINK_IDX : rd_q;
    assign reg_write      = valid_q & (reg_rw_q | link_q) & (write_register != '0);
    assign byp_a          = reg_write & (write_register == id_rs);
    assign byp_b          = reg_write & (write_register == id_rt);

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_count_q, retire_count_d;

    // A stalled write is counted only on the edge where it finally leaves WB.
    always_comb begin
        retire_count_d = retire_count_q;
        if (reset) begin
            retire_count_d = '0;
        end else if (reg_write && !stall) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        retire_count_q <= retire_count_d;
    end

    assign retire_count = retire_count_q;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
MEM/WB pipeline register plus writeback logic. It is the write-side initiator for the register file: it drives regWrite, writeRegister and writeData. The register file commits on the falling clock edge and its read outputs update only when the read addresses change, so this block also supplies a WB-to-ID bypass. It sits between the memory stage and the register file write port.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register index width
LINK_REG, 31, destination index for link (JAL/JALR) writes

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high; clears all state
stall  input  1  hold MEM/WB contents
flush  input  1  insert bubble into MEM/WB
mem_valid  input  1  MEM stage holds a real instruction
mem_reg_write  input  1  instruction writes a register
mem_mem_to_reg  input  1  select load data over ALU result
mem_link  input  1  link instruction; writes PC+8 to LINK_REG
mem_rd  input  ADDR_W  destination register
mem_alu_result  input  DATA_W  ALU result
mem_read_data  input  DATA_W  data memory load result
mem_pc_plus4  input  DATA_W  PC+4 of the instruction
id_rs  input  ADDR_W  ID-stage read address A
id_rt  input  ADDR_W  ID-stage read address B
wb_valid  output  1  WB stage holds a real instruction
reg_write  output  1  register file write enable
write_register  output  ADDR_W  register file write index
write_data  output  DATA_W  register file write data
byp_a  output  1  ID operand A must take write_data
byp_b  output  1  ID operand B must take write_data

Behaviour:
- Reset: reset=1 at posedge clears all MEM/WB state. After that edge: wb_valid=0, reg_write=0, write_register=0, write_data=0, byp_a=0, byp_b=0.
- Update priority at posedge: reset > flush > stall > load.
- Flush: loads a bubble, identical to the reset state. Flush wins over a simultaneous stall.
- Stall: all registered fields hold their values. Outputs stay stable, so the register file rewrites the same value; this is harmless and idempotent.
- Load: captures valid, reg_write, mem_to_reg, link, rd, alu_result, read_data and pc_plus4 from the MEM inputs. Latency is 1 cycle from MEM inputs to the WB outputs.
- Write-data mux, combinational from registered fields:
  - link=1: write_data = pc_plus4 + 4, mod 2^DATA_W (wraps silently).
  - else mem_to_reg=1: write_data = read_data.
  - else: write_data = alu_result.
  - link takes priority over mem_to_reg.
- Destination: write_register = LINK_REG when link=1, else the registered rd.
- Write enable: reg_write = wb_valid & (reg_rw | link) & (write_register != 0).
  - Writes to index 0 are suppressed, so register 0 stays 0.
  - link forces a write even when reg_write was not captured.
- Bypass:
  - byp_a = reg_write & (write_register == id_rs).
  - byp_b = reg_write & (write_register == id_rt).
  - Both are combinational on the id_* inputs and valid in the same cycle.
  - Both are 0 whenever reg_write = 0, which covers bubbles and index 0.
- Reset mid-operation: a pending WB write is discarded, because reg_write drops on the reset edge before the following negedge. Data left in the register file is not touched.
- No combinational path from mem_* inputs to any output.

Optional Feature:
Macro WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count [31:0].
  - It increments on every posedge on which reg_write=1 and stall=0, wrapping at 2^32.
  - Reset clears it. Flush does not.
  - A held (stalled) write counts once, on the cycle it leaves WB.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all outputs 0; byp_a=byp_b=0 with id_rs=id_rt=0.
- ALU writeback: mem_valid=1, mem_reg_write=1, rd=8, alu=0x0000_0010, mem_to_reg=0 -> next cycle reg_write=1, write_register=8, write_data=0x10. With id_rs=8, id_rt=9: byp_a=1, byp_b=0.
- Load and link: mem_to_reg=1, read_data=0xDEAD_BEEF, rd=9 -> write_data=0xDEADBEEF. Then mem_link=1, rd=3, pc_plus4=0x0000_0040 -> write_register=31, write_data=0x44, reg_write=1. pc_plus4=0xFFFF_FFFC -> write_data=0x0000_0000.
- Zero-register suppression: mem_reg_write=1, rd=0, alu=5 -> reg_write=0, byp_a=0 even with id_rs=0.
- Stall/flush priority: load rd=10, alu=7, then stall=1 for 3 cycles with new MEM inputs -> outputs hold rd=10, data=7. Then stall=1 and flush=1 together -> next cycle wb_valid=0, reg_write=0.
- Reset mid-write: valid write to rd=12 in WB, reset asserted at that posedge -> reg_write=0 after the edge. With WB_RETIRE_COUNT_EN defined: 3 unstalled writes -> retire_count=3, then reset -> 0.
